fft_bfu_pipe: RTL

Pipelined, flow-controlled radix-2 butterfly unit that replaces the single-cycle combinational butterfly in the FFT datapath. It adds:
- a three-stage registered datapath with valid/ready handshaking on both sides;
- per-sample inverse-FFT mode (conjugate twiddle);
- per-sample divide-by-two scaling;
- round-to-nearest twiddle multiplication;
- saturation with a sticky overflow flag.

A pass-through tag carries the butterfly's RAM address pair, so the control FSM can issue one butterfly per cycle regardless of latency.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/complex_mult_rnd.sv | 58 +++++
 rtl/fft_bfu_pipe.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared arithmetic helpers for the pipelined FFT butterfly: rounding shift and
// saturate-with-flag, both on 64-bit signed values so any component width fits.
package fft_pkg;

   // Round-half-up arithmetic right shift: (v + 2^(sh-1)) >>> sh.
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                      input int sh);
      return (v + (64'sd1 <<< (sh - 1))) >>> sh;
   endfunction

   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int w,
                                                   output logic hit);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (w - 1));
      hit = (v > hi) || (v < lo);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/complex_mult_rnd.sv
// S1 -> S2 complex multiply b*W: S1 captures b and the (optionally conjugated)
// twiddle, S2 captures the rounded product. Each stage has its own load enable.
module complex_mult_rnd
   import fft_pkg::*;
#(
   parameter int width = 16
) (
   input  logic                 clk,
   input  logic                 en1,
   input  logic                 en2,
   input  logic [2*width-1:0]   b,
   input  logic [2*width-1:0]   twiddle,
   input  logic                 inv,
   output logic [width+1:0]     m_re,
   output logic [width+1:0]     m_im
);

   logic signed [width-1:0]   tw_re;
   logic signed [width-1:0]   tw_im;
   logic signed [width-1:0]   b_re;
   logic signed [width-1:0]   b_im;
   logic signed [width-1:0]   w_re;
   logic signed [width:0]     w_im;
   logic signed [2*width+1:0] br_x;
   logic signed [2*width+1:0] bi_x;
   logic signed [2*width+1:0] wr_x;
   logic signed [2*width+1:0] wi_x;
   logic signed [2*width+1:0] pr;
   logic signed [2*width+1:0] pi;

   assign tw_re = twiddle[2*width-1:width];
   assign tw_im = twiddle[width-1:0];

   // Imag part is held one bit wider so conjugating -2^(width-1) stays exact.
   always_ff @(posedge clk) begin
      if (en1) begin
         b_re <= b[2*width-1:width];
         b_im <= b[width-1:0];
         w_re <= tw_re;
         w_im <= inv ? -((width+1)'(tw_im)) : (width+1)'(tw_im);
      end
   end

   assign br_x = (2*width+2)'(b_re);
   assign bi_x = (2*width+2)'(b_im);
   assign wr_x = (2*width+2)'(w_re);
   assign wi_x = (2*width+2)'(w_im);
   assign pr   = br_x * wr_x - bi_x * wi_x;
   assign pi   = br_x * wi_x + bi_x * wr_x;

   always_ff @(posedge clk) begin
      if (en2) begin
         m_re <= (width+2)'(round_shift(64'(pr), width - 1));
         m_im <= (width+2)'(round_shift(64'(pi), width - 1));
      end
   end

endmodule

// File: rtl/fft_bfu_pipe.sv
// Three-stage valid/ready radix-2 butterfly: aout = A + W*B, bout = A - W*B,
// with per-sample conjugate twiddle, optional /2 scaling and sticky saturation flag.
module fft_bfu_pipe
   import fft_pkg::*;
#(
   parameter int width = 16,
   parameter int tagw  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*width-1:0]   a,
   input  logic [2*width-1:0]   b,
   input  logic [2*width-1:0]   twiddle,
   input  logic                 inv,
   input  logic                 scale,
   input  logic [tagw-1:0]      tag_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*width-1:0]   aout,
   output logic [2*width-1:0]   bout,
   output logic [tagw-1:0]      tag_out,
   output logic                 ovf,
   input  logic                 ovf_clr
);

   logic                    v1, v2, v3;
   logic                    ld1, ld2, ld3;
   logic [2*width-1:0]      a1, a2;
   logic                    scale1, scale2;
   logic [tagw-1:0]         tag1, tag2;
   logic signed [width+1:0] m_re, m_im;
   logic [2*width-1:0]      aout_next, bout_next;
   logic [3:0]              hit;
   logic                    sat_any;

   // Ready ripples back from the output; nothing here depends on in_valid.
   assign ld3      = v2 && (!v3 || out_ready);
   assign ld2      = v1 && (!v2 || ld3);
   assign in_ready = !v1 || ld2;
   assign ld1      = in_valid && in_ready;

   complex_mult_rnd #(.width(width)) u_mult (
      .clk     (clk),
      .en1     (ld1),
      .en2     (ld2),
      .b       (b),
      .twiddle (twiddle),
      .inv     (inv),
      .m_re    (m_re),
      .m_im    (m_im)
   );

   always_ff @(posedge clk) begin
      if (ld1) begin
         a1     <= a;
         scale1 <= scale;
         tag1   <= tag_in;
      end
      if (ld2) begin
         a2     <= a1;
         scale2 <= scale1;
         tag2   <= tag1;
      end
   end

   // Lane 1 is the real component (upper half), lane 0 the imaginary.
   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic signed [width-1:0] a_c;
      logic signed [width+1:0] m_c;
      logic signed [width+2:0] s_raw, d_raw, s_sc, d_sc;
      logic signed [width-1:0] s_sat, d_sat;
      logic                    s_hit, d_hit;

      assign a_c   = a2[gi*width +: width];
      assign m_c   = (gi == 1) ? m_re : m_im;
      assign s_raw = (width+3)'(a_c) + (width+3)'(m_c);
      assign d_raw = (width+3)'(a_c) - (width+3)'(m_c);
      assign s_sc  = scale2 ? (width+3)'(round_shift(64'(s_raw), 1)) : s_raw;
      assign d_sc  = scale2 ? (width+3)'(round_shift(64'(d_raw), 1)) : d_raw;

      always_comb begin
         s_hit = 1'b0;
         d_hit = 1'b0;
         s_sat = width'(saturate(64'(s_sc), width, s_hit));
         d_sat = width'(saturate(64'(d_sc), width, d_hit));
      end

      assign aout_next[gi*width +: width] = s_sat;
      assign bout_next[gi*width +: width] = d_sat;
      assign hit[2*gi +: 2]               = {s_hit, d_hit};
   end

   assign sat_any   = |hit;
   assign out_valid = v3;

   always_ff @(posedge clk) begin
      if (!reset) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         ovf     <= 1'b0;
         aout    <= '0;
         bout    <= '0;
         tag_out <= '0;
      end else begin
         if (ld1)      v1 <= 1'b1;
         else if (ld2) v1 <= 1'b0;
         if (ld2)      v2 <= 1'b1;
         else if (ld3) v2 <= 1'b0;
         if (ld3)            v3 <= 1'b1;
         else if (out_ready) v3 <= 1'b0;
         if (ld3) begin
            aout    <= aout_next;
            bout    <= bout_next;
            tag_out <= tag2;
         end
         // A saturating load takes priority over a simultaneous clear.
         if (ld3 && sat_any) ovf <= 1'b1;
         else if (ovf_clr)   ovf <= 1'b0;
      end
   end

endmodule
